// File: rtl/term_uturn_switch_matrix_cfg.sv
// Configurable south-termination U-turn: reflects S_END back onto N_BEG with index
// reversal, per-wire mode (comb / registered / zero / PRBS) loaded via a serial chain.
module term_uturn_switch_matrix_cfg #(
  parameter int          NUM_WIRES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CFG_BITS  = 2 * NUM_WIRES
) (
  input  logic                 UserCLK,
  input  logic                 RESET,
  input  logic [NUM_WIRES-1:0] S_END,
  output logic [NUM_WIRES-1:0] N_BEG,
  input  logic                 cfg_shift_en,
  input  logic                 cfg_din,
  output logic                 cfg_dout,
  input  logic                 cfg_latch,
  input  logic                 prbs_en,
  output logic [CFG_BITS-1:0]  cfg_active
);

  logic [NUM_WIRES-1:0] rev;
  logic [NUM_WIRES-1:0] pipe_reg;
  logic [CFG_BITS-1:0]  chain_reg;
  logic [CFG_BITS-1:0]  cfg_active_reg;
  logic [15:0]          lfsr_reg;
  logic                 lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // The latch samples the chain before this cycle's shift, so a shift+latch
  // collision commits the old contents while the chain still advances.
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      chain_reg      <= '0;
      cfg_active_reg <= '0;
      pipe_reg       <= '0;
      lfsr_reg       <= LFSR_SEED;
    end else begin
      pipe_reg <= rev;
      if (cfg_shift_en) begin
        chain_reg <= {chain_reg[CFG_BITS-2:0], cfg_din};
      end
      if (cfg_latch) begin
        cfg_active_reg <= chain_reg;
      end
      if (prbs_en) begin
        lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
      end
    end
  end

  assign cfg_dout   = chain_reg[CFG_BITS-1];
  assign cfg_active = cfg_active_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WIRES; gi++) begin : g_wire
      logic [1:0] mode;
      assign rev[gi] = S_END[NUM_WIRES-1-gi];
      assign mode    = cfg_active_reg[2*gi +: 2];
      // Wires beyond 16 reuse the LFSR taps cyclically.
      assign N_BEG[gi] = (mode == 2'b00) ? rev[gi]      :
                         (mode == 2'b01) ? pipe_reg[gi] :
                         (mode == 2'b10) ? 1'b0         :
                                           lfsr_reg[gi % 16];
    end
  endgenerate

endmodule

// File: tb/tb_term_uturn_switch_matrix_cfg.sv
// Bench for term_uturn_switch_matrix_cfg: three widths (4, 1, 64) share stimulus and
// are compared every cycle against a per-wire reference model of the mode rules.
module tb_term_uturn_switch_matrix_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_all;
  logic        sh, din, lat, prbs;

  logic [3:0]   n4;  logic [7:0]   a4;  logic d4;
  logic [0:0]   n1;  logic [1:0]   a1;  logic d1;
  logic [63:0]  n64; logic [127:0] a64; logic d64;

  always #5 clk = ~clk;

  term_uturn_switch_matrix_cfg #(.NUM_WIRES(4)) dut4 (
    .UserCLK(clk), .RESET(rst), .S_END(s_all[3:0]), .N_BEG(n4),
    .cfg_shift_en(sh), .cfg_din(din), .cfg_dout(d4), .cfg_latch(lat),
    .prbs_en(prbs), .cfg_active(a4));

  term_uturn_switch_matrix_cfg #(.NUM_WIRES(1)) dut1 (
    .UserCLK(clk), .RESET(rst), .S_END(s_all[0:0]), .N_BEG(n1),
    .cfg_shift_en(sh), .cfg_din(din), .cfg_dout(d1), .cfg_latch(lat),
    .prbs_en(prbs), .cfg_active(a1));

  term_uturn_switch_matrix_cfg #(.NUM_WIRES(64)) dut64 (
    .UserCLK(clk), .RESET(rst), .S_END(s_all), .N_BEG(n64),
    .cfg_shift_en(sh), .cfg_din(din), .cfg_dout(d64), .cfg_latch(lat),
    .prbs_en(prbs), .cfg_active(a64));

  int checks = 0;
  int errors = 0;

  // Reference state: serial chain and active config per instance, the previous
  // S_END word (the registered mode shows last cycle's reflection) and the PRBS word.
  int           widths [3] = '{4, 1, 64};
  logic [127:0] m_chain [3];
  logic [127:0] m_act   [3];
  logic [63:0]  m_ps;
  logic [15:0]  m_lfsr;

  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    // taps for x^16 + x^14 + x^13 + x^11 + 1
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [127:0] exp_nbeg(int w, logic [127:0] act, logic [63:0] s,
                                            logic [63:0] ps, logic [15:0] l);
    logic [127:0] r = '0;
    for (int i = 0; i < w; i++) begin
      case ((act >> (2 * i)) & 128'd3)
        128'd0:  r[i] = s[w-1-i];
        128'd1:  r[i] = ps[w-1-i];
        128'd2:  r[i] = 1'b0;
        default: r[i] = l[i % 16];
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_chain[d] = '0;
      m_act[d]   = '0;
    end
    m_ps   = '0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      int nb;
      logic [127:0] mask, old;
      nb   = 2 * widths[d];
      mask = (nb >= 128) ? '1 : ((128'd1 << nb) - 128'd1);
      old  = m_chain[d];
      if (sh)  m_chain[d] = ((old << 1) | {127'b0, din}) & mask;
      if (lat) m_act[d] = old;
    end
    m_ps = s_all;
    if (prbs) m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check_all();
    chk("nbeg_w4",  {124'b0, n4},  exp_nbeg(4,  m_act[0], s_all, m_ps, m_lfsr));
    chk("act_w4",   {120'b0, a4},  m_act[0]);
    chk("dout_w4",  {127'b0, d4},  {127'b0, m_chain[0][7]});
    chk("nbeg_w1",  {127'b0, n1},  exp_nbeg(1,  m_act[1], s_all, m_ps, m_lfsr));
    chk("act_w1",   {126'b0, a1},  m_act[1]);
    chk("dout_w1",  {127'b0, d1},  {127'b0, m_chain[1][1]});
    chk("nbeg_w64", {64'b0, n64},  exp_nbeg(64, m_act[2], s_all, m_ps, m_lfsr));
    chk("act_w64",  a64,           m_act[2]);
    chk("dout_w64", {127'b0, d64}, {127'b0, m_chain[2][127]});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    #1;
    check_all();
  endtask

  task automatic shift_bits(logic [127:0] v, int nb);
    for (int k = nb - 1; k >= 0; k--) begin
      sh = 1'b1; din = v[k];
      tick();
    end
    sh = 1'b0; din = 1'b0;
  endtask

  task automatic latch_cfg();
    lat = 1'b1;
    tick();
    lat = 1'b0;
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]   seq;
    logic [15:0]  v0;
    logic [127:0] ones;
    logic         early;

    sh = 0; din = 0; lat = 0; prbs = 0; s_all = 64'd1;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    // reset: everything in combinational U-turn, outputs reversed
    chk("rst_nbeg_w4",  {124'b0, n4}, 128'h8);
    chk("rst_act_w4",   {120'b0, a4}, 128'h0);
    chk("rst_nbeg_w1",  {127'b0, n1}, 128'h1);
    chk("rst_nbeg_w64", {64'b0, n64}, {64'b0, 64'h8000_0000_0000_0000});
    tick();
    chk("rst_hold_nbeg_w4", {124'b0, n4}, 128'h8);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_nbeg_w4", {124'b0, n4}, 128'h8);

    // registered mode on all four wires
    shift_bits(128'h55, 8);
    latch_cfg();
    chk("mode01_act_w4", {120'b0, a4}, 128'h55);
    chk("mode01_act_w1", {126'b0, a1}, 128'h1);
    s_all = 64'h3;
    tick();
    s_all = 64'hC;
    #1;
    chk("mode01_hold_w4", {124'b0, n4}, 128'hC);
    chk("mode01_hold_w1", {127'b0, n1}, 128'h1);
    tick();
    chk("mode01_next_w4", {124'b0, n4}, 128'h3);
    chk("mode01_next_w1", {127'b0, n1}, 128'h0);

    // daisy chain: A5 re-emerges MSB-first; first trailing shift collides with latch
    shift_bits(128'hA5, 8);
    seq[7] = d4;
    for (int j = 0; j < 8; j++) begin
      sh = 1'b1; din = 1'b0; lat = (j == 0);
      tick();
      lat = 1'b0;
      if (j == 0) chk("collision_act_w4", {120'b0, a4}, 128'hA5);
      if (j < 7) seq[6-j] = d4;
    end
    sh = 1'b0;
    chk("daisy_dout_seq", {120'b0, seq}, 128'hA5);

    // PRBS on every wire of every instance
    async_reset_pulse();
    ones = '1;
    shift_bits(ones, 128);
    latch_cfg();
    chk("prbs_act_w4", {120'b0, a4}, 128'hFF);
    chk("prbs_seed_w4", {124'b0, n4}, 128'h1);
    prbs = 1'b1;
    tick();
    prbs = 1'b0;
    chk("prbs_step_w4", {124'b0, n4}, 128'h3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("prbs_freeze_w4", {124'b0, n4}, 128'h3);
    end
    chk("prbs_wrap16", {112'b0, n64[31:16]}, {112'b0, m_lfsr});
    chk("prbs_wrap32", {112'b0, n64[47:32]}, {112'b0, m_lfsr});
    chk("prbs_wrap48", {112'b0, n64[63:48]}, {112'b0, m_lfsr});

    v0 = m_lfsr;
    early = 1'b0;
    prbs = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (i < 65535 && n64[15:0] === v0) early = 1'b1;
    end
    prbs = 1'b0;
    chk("prbs_period_return", {112'b0, n64[15:0]}, {112'b0, v0});
    chk("prbs_period_early",  {127'b0, early}, 128'h0);

    // constant zero, then reset between edges
    shift_bits({64{2'b10}}, 128);
    latch_cfg();
    s_all = 64'hF;
    #1;
    chk("zero_nbeg_w4", {124'b0, n4}, 128'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_nbeg_w4", {124'b0, n4}, 128'hF);
    chk("midrst_act_w4",  {120'b0, a4}, 128'h0);
    check_all();
    #2 rst = 1'b0;
    tick();

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      sh    = 1'($urandom_range(0, 1));
      din   = 1'($urandom_range(0, 1));
      lat   = ($urandom_range(0, 7) == 0);
      prbs  = 1'($urandom_range(0, 1));
      s_all = {$urandom, $urandom};
      if ($urandom_range(0, 79) == 0) begin
        async_reset_pulse();
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
